// File: rtl/operand_loader.sv
// Two-beat operand loader: captures A then B from a shared bus and presents the pair downstream.
// Optional OPERAND_SWAP_EN adds a swap input that reverses the pair order on the B beat.
module operand_loader #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef OPERAND_SWAP_EN
    input  logic             swap,
`endif
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pair_count,
    output logic [1:0]       state_dbg
);

    // Handshakes: a beat moves when in_valid && in_ready, a pair when out_valid && out_ready,
    // both at a rising clk edge; ready never depends on the partner's valid.
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        PRESENT = 2'b10
    } state_t;

    state_t state, state_next;
    logic   a_load, b_load, pair_fire, swap_b;

`ifdef OPERAND_SWAP_EN
    assign swap_b = swap;
`else
    assign swap_b = 1'b0;
`endif

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == PRESENT);
    assign pair_fire = out_valid && out_ready;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        a_load     = 1'b0;
        b_load     = 1'b0;
        case (state)
            LOAD_A: if (in_valid) begin
                a_load     = 1'b1;
                state_next = LOAD_B;
            end
            LOAD_B: if (in_valid) begin
                b_load     = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: if (out_ready) state_next = LOAD_A;
            default: state_next = LOAD_A;
        endcase
        // Abort wins over beat capture; a pair handshake in the same cycle still counts.
        if (clear) begin
            state_next = LOAD_A;
            a_load     = 1'b0;
            b_load     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            out_a      <= '0;
            out_b      <= '0;
            pair_count <= '0;
        end else begin
            state <= state_next;
            if (a_load) out_a <= in_data;
            if (b_load) begin
                if (swap_b) begin
                    out_a <= in_data;
                    out_b <= out_a;
                end else begin
                    out_b <= in_data;
                end
            end
            if (pair_fire) pair_count <= pair_count + 1'b1;
        end
    end

endmodule
